// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: ROM port, decode handshake,
// redirect request and status outputs.
interface instr_fetch_if;
   logic [31:0] rom_addr;
   logic [31:0] rom_dout;
   logic        id_ready;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_valid;
   logic        halted;
   logic        misalign_err;
   logic [15:0] fetch_count;

   modport master (
      output rom_addr,
      input  rom_dout,
      input  id_ready,
      input  redirect_valid,
      input  redirect_target,
      output if_instr,
      output if_pc,
      output if_valid,
      output halted,
      output misalign_err,
      output fetch_count
   );

   modport slave (
      input  rom_addr,
      output rom_dout,
      output id_ready,
      output redirect_valid,
      output redirect_target,
      input  if_instr,
      input  if_pc,
      input  if_valid,
      input  halted,
      input  misalign_err,
      input  fetch_count
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the ROM,
// and registers words into the IF/ID register.
module instr_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          HALT_ZEROS = 2,
   parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
   input  logic clk,
   input  logic rst,
   instr_fetch_if.master bus
);

   typedef enum logic {
      RUN,
      HALTED
   } state_e;

   localparam logic [3:0] ZLAST = 4'(HALT_ZEROS - 1);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ipc_q, ipc_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  zcnt_q, zcnt_d;

   logic redir_ok;
   logic redir_bad;
   logic fire;

   // Qualify the redirect by alignment and decide whether
   // this cycle captures a new word.
   always_comb begin
      redir_ok  = bus.redirect_valid &&
                  (bus.redirect_target[1:0] == 2'b00);
      redir_bad = bus.redirect_valid &&
                  (bus.redirect_target[1:0] != 2'b00);
      fire      = (state_q == RUN) &&
                  (!valid_q || bus.id_ready) &&
                  !redir_ok;
   end

   // Next-state logic: redirect beats fire, fire beats
   // a plain consume; everything else holds.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      zcnt_d  = zcnt_q;
      err_d   = err_q | redir_bad;

      if (redir_ok) begin
         pc_d    = {bus.redirect_target[31:2], 2'b00};
         valid_d = 1'b0;
         instr_d = NOP_WORD;
         zcnt_d  = 4'd0;
         state_d = RUN;
      end else if (fire) begin
         instr_d = bus.rom_dout;
         ipc_d   = pc_q;
         valid_d = 1'b1;
         pc_d    = pc_q + 32'd4;
         if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
         end
         if (bus.rom_dout == 32'd0) begin
            zcnt_d = zcnt_q + 4'd1;
            if (zcnt_q == ZLAST) begin
               state_d = HALTED;
            end
         end else begin
            zcnt_d = 4'd0;
         end
      end else if (valid_q && bus.id_ready) begin
         valid_d = 1'b0;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= {RESET_PC[31:2], 2'b00};
         instr_q <= NOP_WORD;
         ipc_q   <= 32'd0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= 16'd0;
         zcnt_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         zcnt_q  <= zcnt_d;
      end
   end

   assign bus.rom_addr     = pc_q;
   assign bus.if_instr     = instr_q;
   assign bus.if_pc        = ipc_q;
   assign bus.if_valid     = valid_q;
   assign bus.halted       = (state_q == HALTED);
   assign bus.misalign_err = err_q;
   assign bus.fetch_count  = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a random
// phase, all checked against a transaction-level model.
module tb_instr_fetch;

   localparam int          HZ  = 2;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   int          rom_mode = 0;
   logic [31:0] rom_seed = 32'h1234_5678;

   instr_fetch_if bus ();

   instr_fetch #(
      .RESET_PC   (32'h0),
      .HALT_ZEROS (HZ),
      .NOP_WORD   (NOP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(
      input logic [31:0] a,
      input int          mode,
      input logic [31:0] seed
   );
      logic [31:0] h;
      rom_word = 32'd0;
      if (mode == 0) begin
         case (a)
            32'd4:         rom_word = 32'h0080_0693;
            32'd8:         rom_word = 32'h00D7_0023;
            32'd12:        rom_word = 32'h00D7_0833;
            32'hFFFF_FFFC: rom_word = 32'h0000_0033;
            default:       rom_word = 32'd0;
         endcase
      end else if (mode == 1) begin
         rom_word = 32'h0000_0013;
      end else if (a < 32'd256) begin
         h = (a * 32'h9E37_79B1) ^ seed;
         h = h ^ (h >> 15);
         rom_word = (h[1:0] == 2'b00) ? 32'd0 : h;
      end
   endfunction

   assign bus.rom_dout = rom_word(bus.rom_addr, rom_mode, rom_seed);

   // reference model: one transaction per clock
   logic [31:0] m_pc, m_instr, m_ipc;
   logic        m_valid, m_halt, m_err;
   int          m_cnt, m_zeros;

   task automatic model_next(
      input logic rdy, input logic rv,
      input logic [31:0] rt, input logic r
   );
      logic [31:0] w;
      if (r) begin
         m_pc = 0; m_instr = NOP; m_ipc = 0;
         m_valid = 0; m_halt = 0; m_err = 0;
         m_cnt = 0; m_zeros = 0;
      end else if (rv && rt[1:0] == 2'b00) begin
         m_pc = rt; m_valid = 0; m_instr = NOP;
         m_zeros = 0; m_halt = 0;
      end else begin
         if (rv) m_err = 1;
         if (!m_halt && (!m_valid || rdy)) begin
            w = rom_word(m_pc, rom_mode, rom_seed);
            m_instr = w; m_ipc = m_pc; m_valid = 1;
            m_pc = m_pc + 32'd4;
            if (m_cnt < 65535) m_cnt++;
            if (w == 0) begin
               m_zeros++;
               if (m_zeros == HZ) m_halt = 1;
            end else begin
               m_zeros = 0;
            end
         end else if (rdy) begin
            m_valid = 0;
         end
      end
   endtask

   task automatic chk(
      input string tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_model();
      chk("rom_addr", bus.rom_addr, m_pc);
      chk("if_instr", bus.if_instr, m_instr);
      chk("if_pc", bus.if_pc, m_ipc);
      chk("if_valid", {31'd0, bus.if_valid}, {31'd0, m_valid});
      chk("halted", {31'd0, bus.halted}, {31'd0, m_halt});
      chk("misalign", {31'd0, bus.misalign_err}, {31'd0, m_err});
      chk("fetch_count", {16'd0, bus.fetch_count}, m_cnt);
   endtask

   task automatic step(
      input logic rdy, input logic rv,
      input logic [31:0] rt, input logic r
   );
      bus.id_ready        = rdy;
      bus.redirect_valid  = rv;
      bus.redirect_target = rt;
      rst                 = r;
      model_next(rdy, rv, rt, r);
      @(posedge clk);
      #1;
      chk_model();
   endtask

   initial begin
      logic [31:0] exp_pc [6];
      logic [31:0] exp_in [6];
      logic [31:0] rt;
      logic        rv, rdy, r;
      bit          done;
      exp_pc = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20};
      exp_in = '{32'd0, 32'h0080_0693, 32'h00D7_0023,
                 32'h00D7_0833, 32'd0, 32'd0};
      bus.id_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_target = 32'd0;

      // reset state
      step(1, 0, 0, 1);
      chk("rst_pc", bus.rom_addr, 32'd0);
      chk("rst_instr", bus.if_instr, NOP);
      chk("rst_valid", {31'd0, bus.if_valid}, 32'd0);

      // free run to halt
      for (int i = 0; i < 6; i++) begin
         step(1, 0, 0, 0);
         chk("run_pc", bus.if_pc, exp_pc[i]);
         chk("run_instr", bus.if_instr, exp_in[i]);
      end
      chk("run_halted", {31'd0, bus.halted}, 32'd1);
      chk("run_frozen", bus.rom_addr, 32'd24);
      chk("run_count", {16'd0, bus.fetch_count}, 32'd6);
      step(1, 0, 0, 0);
      chk("drain_valid", {31'd0, bus.if_valid}, 32'd0);
      chk("drain_pc", bus.rom_addr, 32'd24);

      // restart from halted
      step(1, 1, 32'h8, 0);
      chk("restart_halt", {31'd0, bus.halted}, 32'd0);
      chk("restart_addr", bus.rom_addr, 32'd8);
      step(1, 0, 0, 0);
      chk("restart_pc", bus.if_pc, 32'd8);

      // backpressure
      step(1, 0, 0, 1);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0);
         chk("bp_pc", bus.if_pc, 32'd4);
         chk("bp_instr", bus.if_instr, 32'h0080_0693);
         chk("bp_valid", {31'd0, bus.if_valid}, 32'd1);
         chk("bp_addr", bus.rom_addr, 32'd8);
      end
      step(1, 0, 0, 0);
      chk("bp_next", bus.if_pc, 32'd8);

      // aligned redirect flushes
      step(1, 1, 32'h4, 0);
      chk("rd_valid", {31'd0, bus.if_valid}, 32'd0);
      chk("rd_instr", bus.if_instr, NOP);
      chk("rd_addr", bus.rom_addr, 32'd4);
      step(1, 0, 0, 0);
      chk("rd_pc", bus.if_pc, 32'd4);
      chk("rd_word", bus.if_instr, 32'h0080_0693);

      // misaligned redirect ignored, error sticky
      step(1, 1, 32'h6, 0);
      chk("mis_err", {31'd0, bus.misalign_err}, 32'd1);
      chk("mis_pc", bus.if_pc, 32'd8);
      chk("mis_addr", bus.rom_addr, 32'd12);
      step(1, 0, 0, 0);
      chk("mis_sticky", {31'd0, bus.misalign_err}, 32'd1);

      // reset during stall
      step(0, 0, 0, 0);
      step(0, 1, 32'h20, 1);
      chk("rs_pc", bus.rom_addr, 32'd0);
      chk("rs_valid", {31'd0, bus.if_valid}, 32'd0);
      chk("rs_instr", bus.if_instr, NOP);
      chk("rs_count", {16'd0, bus.fetch_count}, 32'd0);
      chk("rs_err", {31'd0, bus.misalign_err}, 32'd0);

      // pc wrap and zero-run clearing on redirect
      step(1, 1, 32'hFFFF_FFFC, 0);
      step(1, 0, 0, 0);
      chk("wrap_pc", bus.if_pc, 32'hFFFF_FFFC);
      chk("wrap_addr", bus.rom_addr, 32'd0);
      step(1, 0, 0, 0);
      step(1, 1, 32'd16, 0);
      step(1, 0, 0, 0);
      chk("zclr_run", {31'd0, bus.halted}, 32'd0);
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         step(1, 0, 0, 0);
         done = bus.halted;
      end
      chk("zclr_halt", {31'd0, bus.halted}, 32'd1);
      chk("zclr_last", bus.if_pc, 32'd20);

      // fetch_count saturation
      rom_mode = 1;
      step(1, 0, 0, 1);
      for (int i = 0; i < 65537; i++) begin
         step(1, 0, 0, 0);
      end
      chk("sat_count", {16'd0, bus.fetch_count}, 32'h0000_FFFF);

      // random phase
      rom_mode = 2;
      rom_seed = $urandom;
      step(1, 0, 0, 1);
      for (int i = 0; i < 800; i++) begin
         rdy = ($urandom % 4) != 0;
         rv  = ($urandom % 8) == 0;
         rt  = $urandom_range(0, 300);
         if (($urandom % 4) != 0) rt[1:0] = 2'b00;
         r   = ($urandom % 64) == 0;
         step(rdy, rv, rt, r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
